tcam_match_resolver: RTL and testbench

TCAM_MATCH_RESOLVER -- requirements
Module: tcam_match_resolver

---
 rtl/tcam_match_resolver_if.sv | 33 +++
 rtl/tcam_match_resolver.sv | 105 ++++++++++
 tb/tb_tcam_match_resolver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tcam_match_resolver_if.sv
`default_nettype none
// ============================================================================
// Module   : tcam_match_resolver_if
// Brief    : Match-vector input and address-output handshake bundle.
// Revision : 1.0
// ============================================================================
interface tcam_match_resolver_if #(
    parameter int address_size = 4
);
    localparam int N = 1 << address_size;

    logic [N-1:0]            matched;
    logic                    match_valid;
    logic                    match_ready;
    logic [address_size-1:0] address;
    logic                    address_valid;
    logic                    address_ready;
    logic [address_size:0]   count;
    logic                    hit;
    logic                    done;

    // The master side is the TCAM / consumer environment; the resolver is the slave.
    modport master (
        output matched, match_valid, address_ready,
        input  match_ready, address, address_valid, count, hit, done
    );

    modport slave (
        input  matched, match_valid, address_ready,
        output match_ready, address, address_valid, count, hit, done
    );
endinterface
`default_nettype wire

// File: rtl/tcam_match_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tcam_match_resolver
// Brief    : Serialises a TCAM match vector into lowest-index-first addresses.
// Revision : 1.0
// ============================================================================
module tcam_match_resolver #(
    parameter int address_size = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    tcam_match_resolver_if.slave  bus
);
    localparam int N = 1 << address_size;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [N-1:0]            r_pending;
    logic [N-1:0]            w_pending_rest;
    logic [address_size:0]   r_count;
    logic [address_size:0]   w_popcount;
    logic                    r_hit;
    logic [address_size-1:0] w_low_index;
    logic                    w_accept;
    logic                    w_emit;

    assign w_accept = bus.match_valid & (r_state == IDLE);
    assign w_emit   = (r_state == EMIT) & bus.address_ready;

    // Clearing the lowest set bit leaves exactly the matches still to emit.
    assign w_pending_rest = r_pending & (r_pending - N'(1));

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N; i++) begin
            w_popcount = w_popcount + (address_size + 1)'(bus.matched[i]);
        end
    end

    // Scan downward so the lowest set index is the one that sticks.
    always_comb begin
        w_low_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_index = address_size'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_popcount != '0) ? EMIT : FINISH;
                end
            end
            EMIT: begin
                if (w_emit && (w_pending_rest == '0)) begin
                    w_state_next = FINISH;
                end
            end
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_count   <= '0;
            r_hit     <= 1'b0;
        end else if (w_accept) begin
            r_pending <= bus.matched;
            r_count   <= w_popcount;
            r_hit     <= (w_popcount != '0);
        end else if (w_emit) begin
            r_pending <= w_pending_rest;
        end
    end

    // Gating with reset keeps match_ready low for the whole time reset is held.
    assign bus.match_ready   = reset & (r_state == IDLE);
    assign bus.address_valid = (r_state == EMIT);
    assign bus.address       = (r_state == EMIT) ? w_low_index : '0;
    assign bus.count         = r_count;
    assign bus.hit           = r_hit;
    assign bus.done          = (r_state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_tcam_match_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcam_match_resolver
// Brief    : Directed and randomized checks of the TCAM match resolver.
// Revision : 1.0
// ============================================================================
module tb_tcam_match_resolver;
    localparam int AS = 4;
    localparam int N  = 1 << AS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    tcam_match_resolver_if #(.address_size(AS)) bus ();

    tcam_match_resolver #(.address_size(AS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: consumer always ready; 1: random stalls; 2: first three cycles stalled.
    task automatic run_vector(input logic [N-1:0] v, input int mode, input bit interfere);
        int q[$];
        int guard;
        int cyc;
        int stall;
        bit rdy;
        for (int i = 0; i < N; i++) begin
            if (v[i]) q.push_back(i);
        end
        guard = 0;
        while (bus.match_ready !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        check("ready_before_accept", bus.match_ready, 1);
        bus.matched       = v;
        bus.match_valid   = 1'b1;
        bus.address_ready = 1'b0;
        tick();
        bus.match_valid = 1'b0;
        bus.matched     = N'($urandom);
        check("count", bus.count, $countones(v));
        check("hit", bus.hit, (v != '0));
        cyc   = 0;
        stall = 0;
        while (q.size() > 0 && cyc < 200) begin
            check("addr_valid", bus.address_valid, 1);
            check("addr", bus.address, q[0]);
            check("match_ready_busy", bus.match_ready, 0);
            check("done_busy", bus.done, 0);
            case (mode)
                0:       rdy = 1'b1;
                2:       rdy = (cyc >= 3);
                default: rdy = (stall >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            stall = rdy ? 0 : stall + 1;
            bus.address_ready = rdy;
            if (interfere) begin
                bus.match_valid = 1'b1;
                bus.matched     = 16'h0001;
            end
            tick();
            cyc++;
            if (rdy) void'(q.pop_front());
        end
        bus.match_valid   = 1'b0;
        bus.address_ready = 1'($urandom_range(0, 1));
        check("emit_budget", q.size(), 0);
        check("done", bus.done, 1);
        check("addr_valid_finish", bus.address_valid, 0);
        check("addr_zero_finish", bus.address, 0);
        check("count_hold", bus.count, $countones(v));
        check("hit_hold", bus.hit, (v != '0));
        tick();
        check("done_one_cycle", bus.done, 0);
        check("match_ready_idle", bus.match_ready, 1);
        check("addr_valid_idle", bus.address_valid, 0);
    endtask

    initial begin
        logic [N-1:0] v;
        bus.matched       = '0;
        bus.match_valid   = 1'b0;
        bus.address_ready = 1'b0;

        #2;
        check("rst_match_ready", bus.match_ready, 0);
        check("rst_addr_valid", bus.address_valid, 0);
        check("rst_addr", bus.address, 0);
        check("rst_count", bus.count, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_done", bus.done, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("release_match_ready", bus.match_ready, 1);

        run_vector(16'h0000, 0, 1'b0);
        run_vector(16'h8421, 0, 1'b0);
        run_vector(16'h0006, 2, 1'b0);
        run_vector(16'hFFFF, 0, 1'b0);
        run_vector(16'h0300, 0, 1'b1);

        // Reset in the middle of emitting 0x00F0 drops the remaining matches.
        tick();
        bus.matched     = 16'h00F0;
        bus.match_valid = 1'b1;
        tick();
        bus.match_valid = 1'b0;
        check("mid_addr_first", bus.address, 4);
        check("mid_addr_valid", bus.address_valid, 1);
        bus.address_ready = 1'b1;
        tick();
        check("mid_addr_second", bus.address, 5);
        reset = 1'b0;
        #1;
        check("mid_rst_addr_valid", bus.address_valid, 0);
        check("mid_rst_addr", bus.address, 0);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_hit", bus.hit, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_match_ready", bus.match_ready, 0);
        tick();
        tick();
        check("mid_rst_done_held", bus.done, 0);
        reset = 1'b1;
        #1;
        check("mid_release_match_ready", bus.match_ready, 1);
        check("mid_release_done", bus.done, 0);
        tick();
        check("mid_release_no_done", bus.done, 0);
        run_vector(16'h0A50, 1, 1'b0);

        repeat (150) begin
            case ($urandom_range(0, 4))
                0:       v = N'($urandom);
                1:       v = N'($urandom & $urandom & $urandom);
                2:       v = N'(1) << $urandom_range(0, N - 1);
                3:       v = ~(N'(1) << $urandom_range(0, N - 1));
                default: v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom | $urandom);
            endcase
            run_vector(v, 1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
